// File: rtl/fib_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_calc_pkg
// Description : Shared state encoding and saturation ceiling for the
//               BCD -> binary -> Fibonacci -> BCD display chain.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_calc_pkg;

  typedef enum logic [1:0] {
    e_idle      = 2'd0,
    e_operation = 2'd1,
    e_done      = 2'd2
  } t_state;

  // Largest value the 4-digit display stage can show
  localparam int c_max_result = 9999;

endpackage : fib_calc_pkg
`default_nettype wire

// File: rtl/fib_calc.sv
`default_nettype none
// ============================================================================
// Module      : fib_calc
// Description : Iterative Fibonacci calculator with saturation at MAX_RESULT
//               and a start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_calc
  import fib_calc_pkg::*;
#(
  parameter int N_W        = 12,
  parameter int F_W        = 14,
  parameter int MAX_RESULT = c_max_result
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N_W-1:0] i_n,
  output logic           o_ready,
  output logic           o_done,
  output logic           o_overflow,
  output logic [F_W-1:0] o_fib
);

  localparam logic [F_W:0]   c_max_ext = (F_W+1)'(MAX_RESULT);
  localparam logic [F_W-1:0] c_max_fib = F_W'(MAX_RESULT);

  t_state         r_state;
  logic [F_W-1:0] r_t0;
  logic [F_W-1:0] r_t1;
  logic [N_W-1:0] r_n;
  logic           r_overflow;

  t_state         w_state_nxt;
  logic [F_W-1:0] w_t0_nxt;
  logic [F_W-1:0] w_t1_nxt;
  logic [N_W-1:0] w_n_nxt;
  logic           w_overflow_nxt;
  logic [F_W:0]   w_sum;

  // One bit wider than the operands so the saturation compare never sees a wrap
  assign w_sum = {1'b0, r_t1} + {1'b0, r_t0};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= e_idle;
      r_t0       <= '0;
      r_t1       <= '0;
      r_n        <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_t0       <= w_t0_nxt;
      r_t1       <= w_t1_nxt;
      r_n        <= w_n_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_t0_nxt       = r_t0;
    w_t1_nxt       = r_t1;
    w_n_nxt        = r_n;
    w_overflow_nxt = r_overflow;
    o_ready        = 1'b0;
    o_done         = 1'b0;

    unique case (r_state)
      e_idle: begin
        o_ready = 1'b1;
        if (i_start) begin
          w_n_nxt        = i_n;
          w_t0_nxt       = '0;
          w_t1_nxt       = F_W'(1);
          w_overflow_nxt = 1'b0;
          w_state_nxt    = e_operation;
        end
      end
      e_operation: begin
        if (r_n == '0) begin
          w_t1_nxt    = '0;
          w_state_nxt = e_done;
        end else if (r_n == N_W'(1)) begin
          w_state_nxt = e_done;
        end else if (w_sum > c_max_ext) begin
          // Early exit: further iterations could only grow the result
          w_t1_nxt       = c_max_fib;
          w_overflow_nxt = 1'b1;
          w_state_nxt    = e_done;
        end else begin
          w_t1_nxt = w_sum[F_W-1:0];
          w_t0_nxt = r_t1;
          w_n_nxt  = r_n - N_W'(1);
        end
      end
      e_done: begin
        o_done      = 1'b1;
        w_state_nxt = e_idle;
      end
      default: begin
        w_state_nxt = e_idle;
      end
    endcase
  end

  assign o_fib      = r_t1;
  assign o_overflow = r_overflow;

endmodule : fib_calc
`default_nettype wire

// File: tb/tb_fib_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_calc
// Description : Scoreboard bench for fib_calc with randomized indices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_calc;

  localparam int N_W = 12;
  localparam int F_W = 14;
  localparam int MAX = 9999;

  logic           clk = 1'b0;
  logic           i_rst;
  logic           i_start;
  logic [N_W-1:0] i_n;
  logic           o_ready;
  logic           o_done;
  logic           o_overflow;
  logic [F_W-1:0] o_fib;

  always #5 clk = ~clk;

  fib_calc #(.N_W(N_W), .F_W(F_W), .MAX_RESULT(MAX)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_n        (i_n),
    .o_ready    (o_ready),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_fib      (o_fib)
  );

  typedef struct {
    int n;
    int fib;
    int ovf;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: list the Fibonacci numbers up to the first one above MAX.
  // Indices at or past that point saturate, and the calculator notices
  // the overflow one iteration before reaching it.
  task automatic model(input int n, output int f, output int ovf, output int lat);
    int fibs[$];
    int over_idx;
    fibs.push_back(0);
    fibs.push_back(1);
    while (fibs[fibs.size()-1] <= MAX)
      fibs.push_back(fibs[fibs.size()-1] + fibs[fibs.size()-2]);
    over_idx = fibs.size() - 1;
    if (n >= over_idx) begin
      f = MAX; ovf = 1; lat = over_idx - 1;
    end else begin
      f = fibs[n]; ovf = 0; lat = (n < 2) ? 1 : n;
    end
  endtask

  always @(negedge clk) begin
    if (o_done) begin
      check("ready_low_in_done", int'(o_ready), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("fib(n=%0d)", e.n), int'(o_fib), e.fib);
        check($sformatf("ovf(n=%0d)", e.n), int'(o_overflow), e.ovf);
        check($sformatf("done_cycle(n=%0d)", e.n), cyc, e.done_cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge
  task automatic start(input int n, input bit hold);
    int t = 0;
    int f, ovf, lat;
    exp_t e;
    while (!o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    i_start = 1'b1;
    i_n     = N_W'(n);
    model(n, f, ovf, lat);
    e.n = n; e.fib = f; e.ovf = ovf; e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !o_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || !o_ready) begin
      check("idle_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    int dirs[6] = '{0, 1, 2, 10, 20, 21};
    int bcd[4]  = '{0, 0, 1, 2};
    int t;

    i_rst = 1'b1; i_start = 1'b0; i_n = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(o_ready), 1);
    check("rst_done", int'(o_done), 0);
    check("rst_fib", int'(o_fib), 0);
    check("rst_ovf", int'(o_overflow), 0);
    i_rst = 1'b0;
    @(negedge clk);

    foreach (dirs[i]) begin
      start(dirs[i], 1'b0);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    check("hold_fib_sat", int'(o_fib), MAX);
    check("hold_ovf_sat", int'(o_overflow), 1);

    // Start held high across the whole operation yields a single result
    start(4095, 1'b1);
    t = 0;
    while (!o_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    i_start = 1'b0;
    wait_idle();

    // Start pulse during operation with another index is ignored
    start(10, 1'b0);
    repeat (3) @(negedge clk);
    i_start = 1'b1; i_n = N_W'(3);
    @(negedge clk);
    i_start = 1'b0;
    wait_idle();

    start(7, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("hold_fib_7", int'(o_fib), 13);
    check("hold_ovf_7", int'(o_overflow), 0);

    // Index as the upstream BCD converter would present it
    start(bcd[0] * 1000 + bcd[1] * 100 + bcd[2] * 10 + bcd[3], 1'b0);
    wait_idle();

    // Reset in the middle of a long operation
    start(15, 1'b0);
    repeat (4) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    sb.delete();
    check("midrst_ready", int'(o_ready), 1);
    check("midrst_done", int'(o_done), 0);
    check("midrst_fib", int'(o_fib), 0);
    check("midrst_ovf", int'(o_overflow), 0);
    repeat (20) @(negedge clk);

    for (int k = 0; k < 30; k++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                      : int'($urandom_range(0, 24));
      start(n, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fib_calc
`default_nettype wire
